simd_seq_ctrl: RTL and testbench

//   Run-level sequencer for the SIMD decoder/PE datapath. Takes a host start

---
 rtl/simd_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_simd_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// simd_seq_ctrl
//   Run-level sequencer between the host interface and the SIMD instruction
//   decoder. A host start request walks the block through
//   IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE:
//     CLEAR  holds the decoder in reset for two cycles (PC back to zero),
//     RUN    releases the decoder and paces issue with a one-cycle half_clk
//            strobe every ISSUE_PERIOD cycles, frozen while ext_stall is high,
//     DRAIN  lets the last instruction write back for DRAIN_CYCLES cycles,
//     DONE   pulses done for one cycle with the completion status.
//   Host handshake: start is a level sampled only in IDLE (never queued);
//   done is a single-cycle pulse, and status/cycle_count/instr_count stay
//   valid from that pulse until the next accepted start.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    host run request / host abort
//   prog_len        instructions to issue (0 = run until ins_done_in)
//   ext_stall       downstream busy, freezes the issue phase
//   ins_done_in     decoder end-of-program flag (NOP or PC at max)
//   dec_rstn        decoder synchronous reset, active-low
//   half_clk        one-cycle issue strobe to the decoder
//   stall           stall to decoder/datapath
//   ins_valid       decoder PC wrap permission (held low)
//   busy            high from leaving IDLE until DONE exits
//   done            one-cycle completion pulse
//   status          00 len reached, 01 ins_done, 10 timeout, 11 abort
//   cycle_count     clk cycles in RUN+DRAIN, saturating
//   instr_count     half_clk strobes issued this run, saturating
//   dbg_state       current FSM state encoding
// ---------------------------------------------------------------------------
module simd_seq_ctrl #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ISSUE_PERIOD   = 2,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CNT_WIDTH      = 32,
  parameter int MAX_CYCLES     = 1 << 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [INS_ADDR_WIDTH-1:0] prog_len,
  input  logic                      ext_stall,
  input  logic                      ins_done_in,
  output logic                      dec_rstn,
  output logic                      half_clk,
  output logic                      stall,
  output logic                      ins_valid,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      instr_count,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ST_LEN   = 2'b00;
  localparam logic [1:0] ST_INS   = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  localparam int PH_W = (ISSUE_PERIOD > 1) ? $clog2(ISSUE_PERIOD) : 1;
  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int PAD  = CNT_WIDTH + 1 - INS_ADDR_WIDTH;

  localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(ISSUE_PERIOD - 1);
  localparam logic [DR_W-1:0]      DR_LAST  = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam bit                   TO_EN    = (MAX_CYCLES != 0);
  // With no drain configured a terminating strobe goes straight to DONE.
  localparam state_t               TERM_NXT = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;

  state_t                    r_state;
  state_t                    w_next;
  logic [INS_ADDR_WIDTH-1:0] r_prog_len;
  logic [PH_W-1:0]           r_phase;
  logic                      r_warm;
  logic                      r_clr_cnt;
  logic [DR_W-1:0]           r_drain_cnt;
  logic [1:0]                r_status;
  logic [1:0]                w_next_status;
  logic [CNT_WIDTH-1:0]      r_cycle_count;
  logic [CNT_WIDTH-1:0]      r_instr_count;

  logic                      w_strobe;
  logic                      w_len_hit;
  logic                      w_timeout;
  logic [CNT_WIDTH:0]        w_instr_p1;
  logic [CNT_WIDTH:0]        w_len_ext;

  // The first RUN cycle is a warm-up cycle in which the phase does not move,
  // so the first strobe lands ISSUE_PERIOD cycles after RUN is entered and
  // the decoder has seen dec_rstn high for that long before its first issue.
  assign w_strobe   = (r_state == S_RUN) && !r_warm && (r_phase == PH_LAST) && !ext_stall;
  assign w_instr_p1 = {1'b0, r_instr_count} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_len_ext  = {{PAD{1'b0}}, r_prog_len};
  assign w_len_hit  = (r_prog_len != '0) && (w_instr_p1 == w_len_ext);
  // Fires on the RUN cycle that brings cycle_count up to MAX_CYCLES.
  assign w_timeout  = TO_EN && (r_cycle_count >= TO_LAST);

  // Next-state and status. Priority inside RUN: abort, then program end
  // (ins_done_in over length), then timeout.
  always_comb begin
    w_next        = r_state;
    w_next_status = r_status;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next        = S_CLEAR;
          w_next_status = ST_LEN;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          w_next        = S_DONE;
          w_next_status = ST_ABORT;
        end else if (r_clr_cnt) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next        = S_DONE;
          w_next_status = ST_ABORT;
        end else if (w_strobe && ins_done_in) begin
          w_next        = TERM_NXT;
          w_next_status = ST_INS;
        end else if (w_strobe && w_len_hit) begin
          w_next        = TERM_NXT;
          w_next_status = ST_LEN;
        end else if (w_timeout) begin
          w_next        = S_DONE;
          w_next_status = ST_TOUT;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_next        = S_DONE;
          w_next_status = ST_ABORT;
        end else if (r_drain_cnt == DR_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state outputs.
  always_comb begin
    dec_rstn = 1'b0;
    stall    = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_CLEAR: ;
      S_RUN: begin
        dec_rstn = 1'b1;
        stall    = ext_stall;
      end
      S_DRAIN: begin
        dec_rstn = 1'b1;
        stall    = 1'b0;
      end
      S_DONE: begin
        dec_rstn = 1'b1;
        done     = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_prog_len    <= '0;
      r_phase       <= '0;
      r_warm        <= 1'b1;
      r_clr_cnt     <= 1'b0;
      r_drain_cnt   <= '0;
      r_status      <= ST_LEN;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state  <= w_next;
      r_status <= w_next_status;

      // Previous run's statistics stay visible until the next start edge.
      if (r_state == S_IDLE && start) begin
        r_prog_len    <= prog_len;
        r_cycle_count <= '0;
        r_instr_count <= '0;
      end else begin
        if ((r_state == S_RUN || r_state == S_DRAIN) && !(&r_cycle_count))
          r_cycle_count <= r_cycle_count + 1'b1;
        if (w_strobe && !(&r_instr_count))
          r_instr_count <= r_instr_count + 1'b1;
      end

      r_clr_cnt   <= (r_state == S_CLEAR) ? ~r_clr_cnt : 1'b0;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;

      // Phase is frozen (not reset) by ext_stall so no strobe is lost or
      // doubled across a stall.
      if (r_state != S_RUN) begin
        r_phase <= '0;
        r_warm  <= 1'b1;
      end else if (r_warm) begin
        r_warm <= 1'b0;
      end else if (!ext_stall) begin
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      end
    end
  end

  assign half_clk    = w_strobe;
  // The decoder PC saturates at its maximum instead of wrapping mid-run.
  assign ins_valid   = 1'b0;
  assign status      = r_status;
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_simd_seq_ctrl.sv
module tb_simd_seq_ctrl;

  localparam int AW   = 10;
  localparam int P    = 2;
  localparam int DR   = 3;
  localparam int CW   = 32;
  localparam int MAXC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] prog_len;
  logic          ext_stall;
  logic          ins_done_in;
  logic          dec_rstn;
  logic          half_clk;
  logic          stall;
  logic          ins_valid;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;
  logic [2:0]    dbg_state;

  simd_seq_ctrl #(
    .INS_ADDR_WIDTH(AW),
    .ISSUE_PERIOD  (P),
    .DRAIN_CYCLES  (DR),
    .CNT_WIDTH     (CW),
    .MAX_CYCLES    (MAXC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .prog_len   (prog_len),
    .ext_stall  (ext_stall),
    .ins_done_in(ins_done_in),
    .dec_rstn   (dec_rstn),
    .half_clk   (half_clk),
    .stall      (stall),
    .ins_valid  (ins_valid),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .cycle_count(cycle_count),
    .instr_count(instr_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [1:0]    st;
    logic [CW-1:0] ic;
    logic [CW-1:0] cc;
    bit            chk_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   mon_cyc    = 0;
  int   run_start  = 0;
  int   done_rel   = -1;
  int   strobe_q[$];
  logic prev_dec_rstn = 1'b0;
  logic prev_done     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Expected RUN+DRAIN cycles for a run ending on strobe n with s stall cycles.
  function automatic logic [CW-1:0] exp_cycles(input int n, input int s);
    return CW'(P * n + 1 + s + DR);
  endfunction

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    mon_cyc++;
    if (!rst) begin
      if (dec_rstn && !prev_dec_rstn) run_start = mon_cyc;
      if (half_clk) strobe_q.push_back(mon_cyc - run_start);
      if (prev_done) chk("busy_after_done", {63'd0, busy}, 64'd0);
      if (done) begin
        done_rel = mon_cyc - run_start;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("run_status", {62'd0, status}, {62'd0, mon_e.st});
          if (mon_e.chk_cnt) begin
            chk("run_instr_count", {32'd0, instr_count}, {32'd0, mon_e.ic});
            chk("run_cycle_count", {32'd0, cycle_count}, {32'd0, mon_e.cc});
          end
        end
      end
    end
    prev_dec_rstn = dec_rstn;
    prev_done     = done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic run_until_strobes(input string tag, input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (half_clk === 1'b1) seen++;
      if (seen >= n) break;
    end
    chk({tag, "_strobes_reached"}, 64'(seen), 64'(n));
  endtask

  task automatic start_run(input string tag, input logic [AW-1:0] len, input bit push,
                           input logic [1:0] st, input logic [CW-1:0] ic,
                           input logic [CW-1:0] cc, input bit chk_cnt, input bit with_abort);
    exp_t e;
    strobe_q.delete();
    e.st = st; e.ic = ic; e.cc = cc; e.chk_cnt = chk_cnt;
    if (push) exp_q.push_back(e);
    prog_len = len;
    start    = 1'b1;
    abort    = with_abort;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    // prog_len must have been latched; scribble over it for the rest of the run.
    prog_len = AW'($urandom_range(5, 1023));
    chk({tag, "_clear_busy"},     {63'd0, busy},        64'd1);
    chk({tag, "_clear_dec_rstn"}, {63'd0, dec_rstn},    64'd0);
    chk({tag, "_clear_stall"},    {63'd0, stall},       64'd1);
    chk({tag, "_zero_status"},    {62'd0, status},      64'd0);
    chk({tag, "_zero_instr"},     {32'd0, instr_count}, 64'd0);
    chk({tag, "_zero_cycles"},    {32'd0, cycle_count}, 64'd0);
  endtask

  // Evenly paced run: first strobe P cycles into RUN, then every P cycles,
  // done DRAIN cycles after the cycle following the last strobe.
  task automatic chk_uniform(input string tag, input int n);
    chk({tag, "_strobe_total"}, 64'(strobe_q.size()), 64'(n));
    if (strobe_q.size() == n && n > 0) begin
      chk({tag, "_first_strobe"}, 64'(strobe_q[0]), 64'(P));
      for (int i = 1; i < n; i++)
        chk({tag, "_strobe_gap"}, 64'(strobe_q[i] - strobe_q[i-1]), 64'(P));
      chk({tag, "_drain_len"}, 64'(done_rel - strobe_q[n-1]), 64'(1 + DR));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    prog_len    = '0;
    ext_stall   = 1'b0;
    ins_done_in = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_dec_rstn",  {63'd0, dec_rstn},    64'd0);
    chk("rst_half_clk",  {63'd0, half_clk},    64'd0);
    chk("rst_stall",     {63'd0, stall},       64'd1);
    chk("rst_ins_valid", {63'd0, ins_valid},   64'd0);
    chk("rst_busy",      {63'd0, busy},        64'd0);
    chk("rst_done",      {63'd0, done},        64'd0);
    chk("rst_status",    {62'd0, status},      64'd0);
    chk("rst_cycles",    {32'd0, cycle_count}, 64'd0);
    chk("rst_instr",     {32'd0, instr_count}, 64'd0);
    chk("rst_state",     {61'd0, dbg_state},   64'd0);
    rst = 1'b0;
    tick();

    // A: prog_len=4, no stall; a start pulse while busy must be ignored
    start_run("lenA", AW'(4), 1'b1, 2'b00, CW'(4), exp_cycles(4, 0), 1'b1, 1'b0);
    run_until_strobes("lenA", 1, 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("lenA", 40);
    tick();
    chk("lenA_idle_busy", {63'd0, busy}, 64'd0);
    chk_uniform("lenA", 4);
    repeat (3) begin
      tick();
      chk("lenA_not_queued", {63'd0, busy}, 64'd0);
    end

    // B: prog_len=0, ins_done_in high from the 3rd strobe; start+abort together
    start_run("insB", AW'(0), 1'b1, 2'b01, CW'(3), exp_cycles(3, 0), 1'b1, 1'b1);
    run_until_strobes("insB", 2, 20);
    tick();
    ins_done_in = 1'b1;
    wait_done("insB", 40);
    ins_done_in = 1'b0;
    tick();
    chk_uniform("insB", 3);

    // C: prog_len=4, ext_stall for 5 cycles between strobes 1 and 2
    start_run("stlC", AW'(4), 1'b1, 2'b00, CW'(4), exp_cycles(4, 5), 1'b1, 1'b0);
    run_until_strobes("stlC", 1, 20);
    tick();
    ext_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stlC_stall_high", {63'd0, stall},    64'd1);
      chk("stlC_no_strobe",  {63'd0, half_clk}, 64'd0);
      tick();
    end
    ext_stall = 1'b0;
    #1;
    chk("stlC_stall_low", {63'd0, stall}, 64'd0);
    wait_done("stlC", 40);
    tick();
    chk("stlC_strobe_total", 64'(strobe_q.size()), 64'd4);
    if (strobe_q.size() == 4) begin
      chk("stlC_first_strobe", 64'(strobe_q[0]), 64'(P));
      chk("stlC_delayed_gap",  64'(strobe_q[1] - strobe_q[0]), 64'(P + 5));
      chk("stlC_gap2",         64'(strobe_q[2] - strobe_q[1]), 64'(P));
      chk("stlC_gap3",         64'(strobe_q[3] - strobe_q[2]), 64'(P));
      chk("stlC_drain_len",    64'(done_rel - strobe_q[3]),    64'(1 + DR));
    end

    // D: timeout, prog_len=0 and ins_done_in low
    start_run("toD", AW'(0), 1'b1, 2'b10, CW'((MAXC - 1) / P), CW'(MAXC), 1'b1, 1'b0);
    wait_done("toD", 60);
    tick();
    chk("toD_done_offset",  64'(done_rel),        64'(MAXC));
    chk("toD_strobe_total", 64'(strobe_q.size()), 64'((MAXC - 1) / P));

    // Abort in IDLE is ignored and statistics stay held
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy",   {63'd0, busy},        64'd0);
    chk("idle_held_status",  {62'd0, status},      64'd2);
    chk("idle_held_instr",   {32'd0, instr_count}, 64'((MAXC - 1) / P));
    tick();
    chk("idle_abort_nodone", {63'd0, done},        64'd0);

    // E: abort on the cycle of the final strobe
    start_run("abE", AW'(4), 1'b1, 2'b11, '0, '0, 1'b0, 1'b0);
    run_until_strobes("abE", 4, 30);
    chk("abE_on_strobe", {63'd0, half_clk}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abE_done_next", {63'd0, done},   64'd1);
    chk("abE_status",    {62'd0, status}, 64'd3);
    tick();
    chk("abE_idle", {63'd0, busy}, 64'd0);

    // F: reset asserted during RUN
    start_run("rstF", AW'(4), 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    run_until_strobes("rstF", 2, 20);
    #1;
    rst = 1'b1;
    #1;
    chk("rstF_dec_rstn",  {63'd0, dec_rstn},    64'd0);
    chk("rstF_half_clk",  {63'd0, half_clk},    64'd0);
    chk("rstF_stall",     {63'd0, stall},       64'd1);
    chk("rstF_ins_valid", {63'd0, ins_valid},   64'd0);
    chk("rstF_busy",      {63'd0, busy},        64'd0);
    chk("rstF_done",      {63'd0, done},        64'd0);
    chk("rstF_status",    {62'd0, status},      64'd0);
    chk("rstF_cycles",    {32'd0, cycle_count}, 64'd0);
    chk("rstF_instr",     {32'd0, instr_count}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstF_stays_idle", {63'd0, busy},     64'd0);
    chk("rstF_dec_held",   {63'd0, dec_rstn}, 64'd0);

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
